rr_arbiter4: RTL
================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: maximum consecutive cycles one owner keeps the grant while another requester waits (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4: per-requester request level; bit i high means requester i wants or holds the resource.
REQ-005 SHALL have port gnt, output, 4: registered one-hot grant; all zero when idle.
REQ-006 SHALL have port gnt_id, output, 2: binary index of the granted requester; 0 when idle.
REQ-007 SHALL have port gnt_valid, output, 1: high exactly when gnt is non-zero.
REQ-008 SHALL have port preempt, output, 1: one-cycle pulse, high in the cycle immediately after a grant change caused by hold timeout.

Function
REQ-009 SHALL implement FSM states IDLE and OWNED.
REQ-010 In IDLE, when req is non-zero at a rising edge, SHALL enter OWNED, with gnt, gnt_id and gnt_valid valid after that edge (1-cycle latency).
REQ-011 SHALL select winners round-robin: search starts at (last_id+1) mod 4 and wraps 3->0; the first requester found with req high wins.
REQ-012 SHALL store last_id as the index of the most recent winner; its reset value is 3, so that requester 0 has first priority.
REQ-013 In OWNED, while req[gnt_id] stays high and the hold limit has not been reached, SHALL keep gnt unchanged.
REQ-014 In OWNED, when req[gnt_id] is low at an edge and any other req bit is high, SHALL grant the next round-robin winner on that same edge, with no idle cycle.
REQ-015 In OWNED, when req[gnt_id] is low and req is all zero, SHALL return to IDLE and clear gnt and gnt_valid; gnt_id SHALL return to 0.
REQ-016 SHALL count cycles in OWNED with an 8-bit hold counter; the counter clears on every grant change.
REQ-017 When the hold counter equals MAX_HOLD-1 and another req bit is high, SHALL move the grant to the next round-robin winner and pulse preempt.
REQ-018 When the hold counter reaches MAX_HOLD-1 with no other requester active, SHALL keep the grant and saturate the counter.
REQ-019 SHALL never assert more than one gnt bit.
REQ-020 SHALL never assert a gnt bit whose req bit was low at the granting edge.
REQ-021 When the owner drops req and the hold timeout occur on the same edge, SHALL treat the event as a normal release, with no preempt pulse.

Reset
REQ-022 While rst_n is low, SHALL immediately force state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, counter=0 and last_id=3, regardless of clk.
REQ-023 Reset asserted mid-ownership SHALL drop the grant asynchronously.
REQ-024 After reset deassertion, the first grant SHALL follow REQ-010, with requester 0 highest priority.

Structure
REQ-025 SHALL place the state encoding (IDLE/OWNED), the requester count (4) and the index width (2) in a shared package, rr_arb_pkg.
REQ-026 SHALL contain one sub-module, prio_enc4_v: combinational 4-to-2 priority encoder with a valid output, fed with req rotated by last_id+1.
REQ-027 SHALL derive the winner index as (encoder output + last_id + 1) mod 4.

Verification
REQ-028 Reset release, then req=0001 -> after 1 edge gnt=0001, gnt_id=0, gnt_valid=1.
REQ-029 req=1111 held, with each owner dropping its bit after 2 cycles and re-raising it -> grant order 0,1,2,3,0 with no idle cycles.
REQ-030 MAX_HOLD=8, req=0011 held constant -> gnt=0001 for 8 cycles, then gnt=0010 with preempt high for exactly 1 cycle.
REQ-031 Owner 2 alone holds req=0100 for 20 cycles -> gnt stays 0100 and preempt stays 0 throughout.
REQ-032 rst_n pulsed low mid-cycle while gnt=1000 -> gnt=0000 before the next clk edge; after release, req=1001 -> gnt=0001.
REQ-033 req changes 0010->0000 -> gnt=0000 and gnt_valid=0 after 1 edge; then req=0110 -> gnt=0100, because last_id=1.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
// Also holds the request-rotation helper feeding the priority encoder.
package rr_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Bit k of the result is request (start + k) mod NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rot_req(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDX_W-1:0]   start);
        logic [NUM_REQ-1:0] rot;
        rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot[k] = r[start + IDX_W'(k)];
        end
        return rot;
    endfunction
endpackage

// File: rtl/prio_enc4_v.sv
// Combinational 4-to-2 priority encoder; the lowest set bit wins.
module prio_enc4_v
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a hold limit that forces
// the grant onward while someone else is waiting.
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);
    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_last_id, w_last_nxt;
    logic [IDX_W-1:0]   r_gnt_id, w_id_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_preempt, w_preempt_nxt;

    logic [IDX_W-1:0]   w_start, w_enc_idx, w_win;
    logic               w_enc_vld, w_others, w_hold_lim;

    // Search begins just past the last winner so every requester gets a turn.
    assign w_start = r_last_id + IDX_W'(1);

    prio_enc4_v u_enc (
        .i_req   (rot_req(req, w_start)),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_vld)
    );

    assign w_win      = w_enc_idx + w_start;
    assign w_others   = |(req & ~r_gnt);
    assign w_hold_lim = (r_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last_id;
        w_id_nxt      = r_gnt_id;
        w_gnt_nxt     = r_gnt;
        w_cnt_nxt     = r_cnt;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_enc_vld) begin
                    w_state_nxt = OWNED;
                    w_gnt_nxt   = NUM_REQ'(1) << w_win;
                    w_id_nxt    = w_win;
                    w_last_nxt  = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            OWNED: begin
                if (!req[r_gnt_id]) begin
                    // Release wins over a coincident timeout: no preempt pulse.
                    w_cnt_nxt = '0;
                    if (w_enc_vld) begin
                        w_gnt_nxt  = NUM_REQ'(1) << w_win;
                        w_id_nxt   = w_win;
                        w_last_nxt = w_win;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_id_nxt    = '0;
                    end
                end else if (w_hold_lim) begin
                    if (w_others) begin
                        w_gnt_nxt     = NUM_REQ'(1) << w_win;
                        w_id_nxt      = w_win;
                        w_last_nxt    = w_win;
                        w_cnt_nxt     = '0;
                        w_preempt_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last_id <= IDX_W'(NUM_REQ - 1);
            r_gnt_id  <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_id <= w_last_nxt;
            r_gnt_id  <= w_id_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
    assign preempt   = r_preempt;
endmodule
